alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter LEN_W, default 3, width of cmd_len (max word = 2^LEN_W bytes).
REQ-002 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-004 SHALL have ports cmd_valid in 1, cmd_ready out 1, cmd_op in 2 (0 ADD, 1 SUB, 2 RL, 3 XOR), cmd_len in LEN_W (byte count minus 1), cmd_cin in 1 (initial carry).
REQ-005 SHALL have ports in_valid in 1, in_ready out 1, in_a in 8, in_b in 8: operand byte stream, LSB byte first.
REQ-006 SHALL have ports alu_a out 8, alu_b out 8, alu_cin out 1, alu_f out 4 (drive shared ALU), alu_d in 8, alu_s/alu_z/alu_pv/alu_c in 1 each (ALU results, combinational).
REQ-007 SHALL have ports out_valid out 1, out_ready in 1, out_d out 8, out_last out 1: result byte stream.
REQ-008 SHALL have ports done out 1 (one-cycle pulse), flag_c, flag_z, flag_s, flag_v out 1 each (whole-word flags).

Function
REQ-009 SHALL implement FSM IDLE, RUN, FLUSH; cmd_ready=1 only in IDLE.
REQ-010 IDLE: on cmd_valid&cmd_ready SHALL latch op, len, load carry_r<=cmd_cin, zacc<=1, byte count<=0, go RUN.
REQ-011 alu_f SHALL be ADC(6) for ADD, SBC(8) for SUB, RL(13) for RL, XOR(11) for XOR; alu_a=in_a, alu_b=in_b, alu_cin=carry_r.
REQ-012 RUN: in_ready SHALL equal (!out_valid | out_ready); in IDLE/FLUSH in_ready=0.
REQ-013 On input handshake SHALL register out_d<=alu_d, out_valid<=1, carry_r<=alu_c, zacc<=zacc&alu_z, count+1; latency one cycle (operand accepted cycle N, out_valid at N+1).
REQ-014 On handshake of byte count==len SHALL set out_last=1 with that byte and go FLUSH; count SHALL NOT wrap past len.
REQ-015 out_d/out_last/out_valid SHALL hold stable while out_valid&!out_ready; out_valid clears on out_ready unless a new byte is loaded same cycle.
REQ-016 FLUSH: on out_valid&out_ready&out_last SHALL pulse done next cycle, go IDLE same edge; flags valid from done onward, held until next command accepted.
REQ-017 Flags: flag_c=final carry_r (borrow for SUB, 0 for XOR), flag_z=zacc (all bytes zero), flag_s=last alu_s, flag_v=last alu_pv (overflow for ADD/SUB, parity for RL/XOR).
REQ-018 cmd_valid in RUN/FLUSH SHALL be ignored; in_valid in IDLE SHALL be ignored.

Reset
REQ-019 rst_n=0 at any edge, including mid-operation, SHALL force IDLE, out_valid=0, out_last=0, out_d=0, done=0, all flags=0, carry_r=0, count=0; partial word discarded.
REQ-020 cmd_ready SHALL be 1 in the first cycle after rst_n deasserts.

Configuration
REQ-021 With ALU_SEQ_ABORT_EN defined SHALL add port abort in 1: abort=1 in RUN/FLUSH forces IDLE next edge, clears out_valid/out_last, no done pulse, flags unchanged.
REQ-022 Without ALU_SEQ_ABORT_EN the abort port SHALL not exist and commands always run to completion.

Verification
REQ-023 ADD len=1 cin=0, A=0xFF,0x00 B=0x01,0x00 -> out 0x00,0x01 (last on 2nd), flag_c=0 z=0 v=0, done once.
REQ-024 SUB len=1 cin=0, A=0x00,0x00 B=0x01,0x00 -> out 0xFF,0xFF, flag_c=1 s=1 z=0.
REQ-025 XOR len=2, A=B=0x5A x3 -> out 0x00 x3, flag_z=1, flag_c=0.
REQ-026 RL len=1 cin=1, B=0x80,0x01 -> out 0x01,0x03, flag_c=0.
REQ-027 ADD len=3, out_ready low 3 cycles after 1st byte -> in_ready=0, out_d stable, no byte lost/duplicated.
REQ-028 rst_n low during 2nd byte of len=3 -> all outputs at reset values next cycle, no done; following ADD len=0 0x01+0x01 -> 0x02.

Source files
------------

// File: rtl/alu_seq.sv
// Multi-byte ALU sequencer: streams LSB-first operand bytes through a shared
// byte ALU, chaining carry and collecting whole-word flags. Optional abort port under ALU_SEQ_ABORT_EN.
module alu_seq #(
  parameter int LEN_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef ALU_SEQ_ABORT_EN
  input  logic             abort,
`endif
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             cmd_cin,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic             alu_cin,
  output logic [3:0]       alu_f,
  input  logic [7:0]       alu_d,
  input  logic             alu_s,
  input  logic             alu_z,
  input  logic             alu_pv,
  input  logic             alu_c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_d,
  output logic             out_last,
  output logic             done,
  output logic             flag_c,
  output logic             flag_z,
  output logic             flag_s,
  output logic             flag_v
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;
  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_RL, OP_XOR} op_t;

  localparam logic [3:0] F_ADC = 4'd6;
  localparam logic [3:0] F_SBC = 4'd8;
  localparam logic [3:0] F_XOR = 4'd11;
  localparam logic [3:0] F_RL  = 4'd13;

  state_t           r_state, w_next_state;
  op_t              r_op;
  logic [LEN_W-1:0] r_len, r_count;
  logic             r_carry, r_zacc, r_s_last, r_pv_last;
  logic [7:0]       r_out_d;
  logic             r_out_valid, r_out_last, r_done;
  logic             r_flag_c, r_flag_z, r_flag_s, r_flag_v;

  logic w_abort, w_cmd_fire, w_in_fire, w_out_fire, w_last_byte, w_finish;

`ifdef ALU_SEQ_ABORT_EN
  assign w_abort = abort & (r_state != S_IDLE);
`else
  assign w_abort = 1'b0;
`endif

  assign w_cmd_fire  = cmd_valid & cmd_ready;
  assign w_in_fire   = in_valid & in_ready;
  assign w_out_fire  = r_out_valid & out_ready;
  assign w_last_byte = (r_count == r_len);
  assign w_finish    = (r_state == S_FLUSH) & w_out_fire & r_out_last;

  assign alu_a   = in_a;
  assign alu_b   = in_b;
  assign alu_cin = r_carry;

  // NOTE: every output of this block is defaulted first so no path can infer a latch.
  always_comb begin
    w_next_state = r_state;
    cmd_ready    = 1'b0;
    in_ready     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) w_next_state = S_RUN;
      end
      S_RUN: begin
        in_ready = ~r_out_valid | out_ready;
        if (in_valid && in_ready && w_last_byte) w_next_state = S_FLUSH;
      end
      S_FLUSH: begin
        if (w_finish) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
    if (w_abort) w_next_state = S_IDLE;
  end

  always_comb begin
    alu_f = F_ADC;
    unique case (r_op)
      OP_ADD: alu_f = F_ADC;
      OP_SUB: alu_f = F_SBC;
      OP_RL:  alu_f = F_RL;
      OP_XOR: alu_f = F_XOR;
      default: alu_f = F_ADC;
    endcase
  end

  // NOTE: reset is sampled on the clock edge only; it is not in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_op        <= OP_ADD;
      r_len       <= '0;
      r_count     <= '0;
      r_carry     <= 1'b0;
      r_zacc      <= 1'b0;
      r_s_last    <= 1'b0;
      r_pv_last   <= 1'b0;
      r_out_d     <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_done      <= 1'b0;
      r_flag_c    <= 1'b0;
      r_flag_z    <= 1'b0;
      r_flag_s    <= 1'b0;
      r_flag_v    <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_done  <= w_finish & ~w_abort;

      if (w_cmd_fire) begin
        r_op    <= op_t'(cmd_op);
        r_len   <= cmd_len;
        r_carry <= cmd_cin;
        r_zacc  <= 1'b1;
        r_count <= '0;
      end

      // A byte arriving in the same cycle as the consumer pops keeps out_valid high.
      if (w_abort) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end else if (w_in_fire) begin
        r_out_d     <= alu_d;
        r_out_valid <= 1'b1;
        r_out_last  <= w_last_byte;
        r_carry     <= alu_c;
        r_zacc      <= r_zacc & alu_z;
        r_s_last    <= alu_s;
        r_pv_last   <= alu_pv;
        if (!w_last_byte) r_count <= r_count + LEN_W'(1);
      end else if (w_out_fire) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end

      if (w_finish && !w_abort) begin
        r_flag_c <= r_carry;
        r_flag_z <= r_zacc;
        r_flag_s <= r_s_last;
        r_flag_v <= r_pv_last;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_d     = r_out_d;
  assign out_last  = r_out_last;
  assign done      = r_done;
  assign flag_c    = r_flag_c;
  assign flag_z    = r_flag_z;
  assign flag_s    = r_flag_s;
  assign flag_v    = r_flag_v;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: models the shared byte ALU, drives directed word commands,
// and scoreboards the result byte stream and whole-word flags.
module tb_alu_seq;

  localparam int LEN_W = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmd_valid, cmd_cin;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [LEN_W-1:0] cmd_len;
  logic             in_valid, in_ready;
  logic [7:0]       in_a, in_b;
  logic [7:0]       alu_a, alu_b, alu_d;
  logic             alu_cin, alu_s, alu_z, alu_pv, alu_c;
  logic [3:0]       alu_f;
  logic             out_valid, out_ready, out_last;
  logic [7:0]       out_d;
  logic             done, flag_c, flag_z, flag_s, flag_v;

  always #5 clk = ~clk;

  alu_seq #(.LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_len(cmd_len), .cmd_cin(cmd_cin),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_f(alu_f),
    .alu_d(alu_d), .alu_s(alu_s), .alu_z(alu_z), .alu_pv(alu_pv), .alu_c(alu_c),
    .out_valid(out_valid), .out_ready(out_ready), .out_d(out_d), .out_last(out_last),
    .done(done), .flag_c(flag_c), .flag_z(flag_z), .flag_s(flag_s), .flag_v(flag_v)
  );

  // Byte ALU model: ADC=6, SBC=8 (carry is borrow), XOR=11, RL=13 (rotates b through carry).
  typedef struct packed {
    logic [7:0] d;
    logic       c;
    logic       s;
    logic       z;
    logic       pv;
  } alu_res_t;

  function automatic alu_res_t alu_model(input logic [3:0] f, input logic [7:0] a,
                                         input logic [7:0] b, input logic cin);
    alu_res_t   r;
    logic [8:0] t;
    r = '0;
    case (f)
      4'd6: begin
        t    = {1'b0, a} + {1'b0, b} + 9'(cin);
        r.d  = t[7:0];
        r.c  = t[8];
        r.pv = (a[7] == b[7]) && (r.d[7] != a[7]);
      end
      4'd8: begin
        t    = {1'b0, a} - {1'b0, b} - 9'(cin);
        r.d  = t[7:0];
        r.c  = t[8];
        r.pv = (a[7] != b[7]) && (r.d[7] != a[7]);
      end
      4'd13: begin
        r.d  = {b[6:0], cin};
        r.c  = b[7];
        r.pv = ~^r.d;
      end
      4'd11: begin
        r.d  = a ^ b;
        r.c  = 1'b0;
        r.pv = ~^r.d;
      end
      default: r.d = 8'h00;
    endcase
    r.s = r.d[7];
    r.z = (r.d == 8'h00);
    return r;
  endfunction

  alu_res_t alu_r;
  always_comb alu_r = alu_model(alu_f, alu_a, alu_b, alu_cin);
  assign alu_d  = alu_r.d;
  assign alu_c  = alu_r.c;
  assign alu_s  = alu_r.s;
  assign alu_z  = alu_r.z;
  assign alu_pv = alu_r.pv;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  logic [8:0] exp_q[$];
  logic [8:0] mon_e;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: a byte is consumed at the edge following a negedge with valid&ready.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_byte", 64'(exp_q.size()), 64'd1);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_byte", {out_last, out_d}, mon_e);
      end
    end
    if (done === 1'b1) done_cnt++;
  end

  task automatic do_cmd(input logic [1:0] op, input int len, input logic cin);
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_len   = len[LEN_W-1:0];
    cmd_cin   = cin;
    @(negedge clk);
    while (cmd_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (cmd_ready !== 1'b1) check("cmd_ready_timeout", cmd_ready, 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] a, input logic [7:0] b);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) check("in_ready_timeout", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input logic [3:0] exp_flags);
    int n;
    n = 0;
    @(negedge clk);
    while (done !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, done, 1);
    check({tag, "_flags_czsv"}, {flag_c, flag_z, flag_s, flag_v}, exp_flags);
    @(posedge clk);
    #1;
  endtask

  // One full command; words are LSB byte first. noise holds cmd_valid high during RUN.
  task automatic run_word(input string tag, input logic [1:0] op, input int len,
                          input logic cin, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp_d, input logic [3:0] exp_flags,
                          input logic noise);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i <= len; i++) exp_q.push_back({(i == len), exp_d[8*i +: 8]});
    do_cmd(op, len, cin);
    if (noise) begin
      cmd_valid = 1'b1;
      cmd_op    = ~op;
      cmd_len   = '0;
      @(negedge clk);
      check({tag, "_cmd_ready_run"}, cmd_ready, 0);
      @(posedge clk);
      #1;
    end
    for (int i = 0; i <= len; i++) send_byte(a[8*i +: 8], b[8*i +: 8]);
    cmd_valid = 1'b0;
    wait_done(tag, exp_flags);
    @(negedge clk);
    check({tag, "_done_pulse_low"}, done, 0);
    check({tag, "_done_count"}, 64'(done_cnt - d0), 64'd1);
    check({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_len   = '0;
    cmd_cin   = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out", {out_valid, out_last, out_d, done}, 11'h000);
    check("rst_flags", {flag_c, flag_z, flag_s, flag_v}, 4'h0);
    check("rst_in_ready", in_ready, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("cmd_ready_after_rst", cmd_ready, 1);

    // Operand bytes offered while idle must be ignored.
    in_valid = 1'b1;
    in_a     = 8'h12;
    in_b     = 8'h34;
    repeat (2) @(negedge clk);
    check("idle_in_ready", in_ready, 0);
    check("idle_out_valid", out_valid, 0);
    @(posedge clk);
    #1 in_valid = 1'b0;

    run_word("add_carry", 2'd0, 1, 1'b0, 64'h00FF, 64'h0001, 64'h0100, 4'b0000, 1'b0);
    run_word("sub_borrow", 2'd1, 1, 1'b0, 64'h0000, 64'h0001, 64'hFFFF, 4'b1010, 1'b0);
    run_word("xor_zero", 2'd3, 2, 1'b0, 64'h5A5A5A, 64'h5A5A5A, 64'h000000, 4'b0101, 1'b1);
    run_word("rl_chain", 2'd2, 1, 1'b1, 64'h0000, 64'h0180, 64'h0301, 4'b0001, 1'b0);
    run_word("add_maxlen", 2'd0, 7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,
             64'h0, 4'b1100, 1'b0);

    // Backpressure: consumer stalls three cycles after the first result byte.
    d0 = done_cnt;
    exp_q.push_back({1'b0, 8'h10});
    exp_q.push_back({1'b0, 8'h01});
    exp_q.push_back({1'b0, 8'h01});
    exp_q.push_back({1'b1, 8'h80});
    do_cmd(2'd0, 3, 1'b0);
    send_byte(8'hF0, 8'h20);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_a      = 8'h0F;
    in_b      = 8'hF1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_in_ready", in_ready, 0);
      check("stall_out_hold", {out_valid, out_last, out_d}, {1'b1, 1'b0, 8'h10});
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    send_byte(8'h0F, 8'hF1);
    send_byte(8'h80, 8'h80);
    send_byte(8'h7F, 8'h00);
    wait_done("stall", 4'b0011);
    check("stall_done_count", 64'(done_cnt - d0), 64'd1);
    check("stall_sb_empty", 64'(exp_q.size()), 64'd0);

    // Reset in the middle of a word: partial result discarded, no done pulse.
    d0 = done_cnt;
    exp_q.push_back({1'b0, 8'h33});
    do_cmd(2'd0, 3, 1'b0);
    send_byte(8'h11, 8'h22);
    in_valid = 1'b1;
    in_a     = 8'h44;
    in_b     = 8'h55;
    rst_n    = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("midrst_out", {out_valid, out_last, out_d, done}, 11'h000);
    check("midrst_flags", {flag_c, flag_z, flag_s, flag_v}, 4'h0);
    check("midrst_cmd_ready", cmd_ready, 1);
    check("midrst_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);
    check("midrst_no_done", 64'(done_cnt - d0), 64'd0);
    check("midrst_sb_empty", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
    run_word("add_after_rst", 2'd0, 0, 1'b0, 64'h01, 64'h01, 64'h02, 4'b0000, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
